sha_func_sequencer: RTL and testbench

//  Sequences one shared combinational ALU (ADD/SUB/AND/OR/SLL/SRA/XOR/ROTR) to compute the
//  SHA-256 compression helpers Σ0(x), Σ1(x) and Maj(x,y,z) as multi-cycle micro-programs.

---
 rtl/sha_func_sequencer_pkg.sv | 56 +++++
 rtl/sha_func_sequencer_rom.sv | 64 ++++++
 rtl/sha_func_sequencer.sv | 164 ++++++++++++++++
 tb/tb_sha_func_sequencer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/sha_func_sequencer_pkg.sv
// Shared types for the SHA-256 helper sequencer: ALU opcodes, func codes, FSM states, micro-op format.
// Optional feature macro: SHA_SEQ_ADD3_EN (func 3 = x+y+z).
package sha_seq_pkg;

  localparam int W      = 32;
  localparam int NSTEP  = 5;
  localparam int STEP_W = $clog2(NSTEP);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SLL  = 5'd4;
  localparam logic [4:0] OP_SRA  = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_ROTR = 5'd7;

  localparam logic [1:0] FUNC_S0   = 2'd0;
  localparam logic [1:0] FUNC_S1   = 2'd1;
  localparam logic [1:0] FUNC_MAJ  = 2'd2;
  localparam logic [1:0] FUNC_ADD3 = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {SRC_X, SRC_Y, SRC_Z, SRC_ACC, SRC_TMP, SRC_ZERO} src_t;
  typedef enum logic {DST_TMP, DST_ACC} dst_t;

  typedef struct packed {
    logic [4:0] opcode;
    src_t       src_a;
    src_t       src_b;
    logic [4:0] shamt;
    dst_t       dst;
    logic       last;
  } uop_t;

  function automatic uop_t mk_uop(input logic [4:0] op, input src_t a, input src_t b,
                                  input logic [4:0] sh, input dst_t d, input logic l);
    uop_t u;
    u.opcode = op;
    u.src_a  = a;
    u.src_b  = b;
    u.shamt  = sh;
    u.dst    = d;
    u.last   = l;
    return u;
  endfunction

  function automatic logic func_supported(input logic [1:0] f);
`ifdef SHA_SEQ_ADD3_EN
    return 1'b1;
`else
    return (f != FUNC_ADD3);
`endif
  endfunction

endpackage

// File: rtl/sha_func_sequencer_rom.sv
// Micro-program ROM: (func, step) -> ALU micro-op. Func 3 program present only with SHA_SEQ_ADD3_EN.
module sha_seq_rom
  import sha_seq_pkg::*;
(
  input  logic [1:0]        i_func,
  input  logic [STEP_W-1:0] i_step,
  output uop_t              o_uop
);

  logic [4:0] w_r0, w_r1, w_r2;

  // Rotation amounts distinguish Sigma0 from Sigma1; the program shape is shared.
  always_comb begin
    w_r0 = 5'd2;
    w_r1 = 5'd13;
    w_r2 = 5'd22;
    if (i_func == FUNC_S1) begin
      w_r0 = 5'd6;
      w_r1 = 5'd11;
      w_r2 = 5'd25;
    end else begin
      w_r0 = 5'd2;
      w_r1 = 5'd13;
      w_r2 = 5'd22;
    end
  end

  // Program table lookup.
  always_comb begin
    o_uop = mk_uop(OP_ADD, SRC_ZERO, SRC_ZERO, 5'd0, DST_TMP, 1'b0);
    case (i_func)
      FUNC_S0, FUNC_S1: begin
        case (i_step)
          3'd0:    o_uop = mk_uop(OP_ROTR, SRC_X,   SRC_ZERO, w_r0, DST_TMP, 1'b0);
          3'd1:    o_uop = mk_uop(OP_ROTR, SRC_X,   SRC_ZERO, w_r1, DST_ACC, 1'b0);
          3'd2:    o_uop = mk_uop(OP_XOR,  SRC_ACC, SRC_TMP,  5'd0, DST_ACC, 1'b0);
          3'd3:    o_uop = mk_uop(OP_ROTR, SRC_X,   SRC_ZERO, w_r2, DST_TMP, 1'b0);
          3'd4:    o_uop = mk_uop(OP_XOR,  SRC_ACC, SRC_TMP,  5'd0, DST_ACC, 1'b1);
          default: o_uop = mk_uop(OP_ADD,  SRC_ZERO, SRC_ZERO, 5'd0, DST_TMP, 1'b1);
        endcase
      end
      FUNC_MAJ: begin
        case (i_step)
          3'd0:    o_uop = mk_uop(OP_AND, SRC_X,   SRC_Y,   5'd0, DST_TMP, 1'b0);
          3'd1:    o_uop = mk_uop(OP_AND, SRC_X,   SRC_Z,   5'd0, DST_ACC, 1'b0);
          3'd2:    o_uop = mk_uop(OP_XOR, SRC_ACC, SRC_TMP, 5'd0, DST_ACC, 1'b0);
          3'd3:    o_uop = mk_uop(OP_AND, SRC_Y,   SRC_Z,   5'd0, DST_TMP, 1'b0);
          3'd4:    o_uop = mk_uop(OP_XOR, SRC_ACC, SRC_TMP, 5'd0, DST_ACC, 1'b1);
          default: o_uop = mk_uop(OP_ADD, SRC_ZERO, SRC_ZERO, 5'd0, DST_TMP, 1'b1);
        endcase
      end
`ifdef SHA_SEQ_ADD3_EN
      FUNC_ADD3: begin
        case (i_step)
          3'd0:    o_uop = mk_uop(OP_ADD, SRC_X,   SRC_Y, 5'd0, DST_TMP, 1'b0);
          default: o_uop = mk_uop(OP_ADD, SRC_TMP, SRC_Z, 5'd0, DST_ACC, 1'b1);
        endcase
      end
`endif
      default: o_uop = mk_uop(OP_ADD, SRC_ZERO, SRC_ZERO, 5'd0, DST_TMP, 1'b1);
    endcase
  end

endmodule

// File: rtl/sha_func_sequencer.sv
// Sequences an external shared ALU through Sigma0/Sigma1/Maj micro-programs behind valid/ready.
// Optional feature macro: SHA_SEQ_ADD3_EN (func 3 = x+y+z, 2-step program).
module sha_func_sequencer
  import sha_seq_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_func,
  input  logic [W-1:0] req_x,
  input  logic [W-1:0] req_y,
  input  logic [W-1:0] req_z,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic         busy,
  output logic [W-1:0] alu_opA,
  output logic [W-1:0] alu_opB,
  output logic [4:0]   alu_opcode,
  output logic [4:0]   alu_shamt,
  input  logic [W-1:0] alu_result
);

  state_t            r_state, w_state_nxt;
  logic [STEP_W-1:0] r_step;
  logic [1:0]        r_func;
  logic [W-1:0]      r_x, r_y, r_z, r_acc, r_tmp;
  logic              r_rsp_valid, r_rsp_err;
  logic [W-1:0]      r_rsp_data;
  uop_t              w_uop;
  logic              w_accept;

  sha_seq_rom u_rom (
    .i_func (r_func),
    .i_step (r_step),
    .o_uop  (w_uop)
  );

  function automatic logic [W-1:0] pick(input src_t s, input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic [W-1:0] z, input logic [W-1:0] acc,
                                        input logic [W-1:0] tmp);
    case (s)
      SRC_X:   return x;
      SRC_Y:   return y;
      SRC_Z:   return z;
      SRC_ACC: return acc;
      SRC_TMP: return tmp;
      default: return {W{1'b0}};
    endcase
  endfunction

  assign w_accept  = req_valid && (r_state == IDLE);
  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = func_supported(req_func) ? RUN : DONE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_uop.last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ALU pins are quiet outside RUN so the shared ALU sees no activity from us.
  always_comb begin
    alu_opA    = {W{1'b0}};
    alu_opB    = {W{1'b0}};
    alu_opcode = 5'd0;
    alu_shamt  = 5'd0;
    if (r_state == RUN) begin
      alu_opA    = pick(w_uop.src_a, r_x, r_y, r_z, r_acc, r_tmp);
      alu_opB    = pick(w_uop.src_b, r_x, r_y, r_z, r_acc, r_tmp);
      alu_opcode = w_uop.opcode;
      alu_shamt  = w_uop.shamt;
    end else begin
      alu_opA    = {W{1'b0}};
      alu_opB    = {W{1'b0}};
      alu_opcode = 5'd0;
      alu_shamt  = 5'd0;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Request capture, micro-step execution and response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_step      <= '0;
      r_func      <= 2'd0;
      r_x         <= {W{1'b0}};
      r_y         <= {W{1'b0}};
      r_z         <= {W{1'b0}};
      r_acc       <= {W{1'b0}};
      r_tmp       <= {W{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= {W{1'b0}};
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_step <= '0;
            r_func <= req_func;
            r_x    <= req_x;
            r_y    <= req_y;
            r_z    <= req_z;
            if (!func_supported(req_func)) begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= {W{1'b0}};
              r_rsp_err   <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_uop.dst == DST_TMP) r_tmp <= alu_result;
          else                      r_acc <= alu_result;
          if (w_uop.last) begin
            r_step      <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= alu_result;
            r_rsp_err   <= 1'b0;
          end else begin
            r_step <= r_step + 3'd1;
          end
        end
        DONE: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_func_sequencer.sv
// Directed self-checking bench for sha_func_sequencer with a behavioural ALU model.
module tb_sha_func_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_func = 2'd0;
  logic [31:0] req_x = 32'd0, req_y = 32'd0, req_z = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [31:0] alu_opA, alu_opB, alu_result;
  logic [4:0]  alu_opcode, alu_shamt;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sha_func_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opcode(alu_opcode),
    .alu_shamt(alu_shamt), .alu_result(alu_result)
  );

  // Reference ALU
  always_comb begin
    case (alu_opcode)
      5'd0:    alu_result = alu_opA + alu_opB;
      5'd1:    alu_result = alu_opA - alu_opB;
      5'd2:    alu_result = alu_opA & alu_opB;
      5'd3:    alu_result = alu_opA | alu_opB;
      5'd4:    alu_result = alu_opA << alu_shamt;
      5'd5:    alu_result = $signed(alu_opA) >>> alu_shamt;
      5'd6:    alu_result = alu_opA ^ alu_opB;
      5'd7:    alu_result = (alu_opA >> alu_shamt) | (alu_opA << (6'd32 - {1'b0, alu_shamt}));
      default: alu_result = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [1:0] f, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] z);
    @(negedge clock);
    req_func = f; req_x = x; req_y = y; req_z = z; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat, input logic [31:0] exp_data,
                          input logic exp_err);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_data"}, {32'd0, rsp_data}, {32'd0, exp_data});
    check({tag, "_err"}, {63'd0, rsp_err}, {63'd0, exp_err});
  endtask

  task automatic finish_rsp(input string tag);
    @(negedge clock); rsp_ready = 1'b1;
    @(posedge clock); #1; rsp_ready = 1'b0;
    check({tag, "_done"}, {62'd0, rsp_valid, req_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  initial begin
    logic [31:0] held;
    #12;
    check("reset_out", {rsp_valid, rsp_err, busy, req_ready, rsp_data, 28'd0},
                       {1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 28'd0});
    check("reset_alu", {alu_opA, alu_opB}, 64'd0);
    @(negedge clock); reset_n = 1'b1;

    // Sigma0 with first-step ALU pin check
    start_req(2'd0, 32'h6a09e667, 32'd0, 32'd0);
    check("s0_step0_pins", {22'd0, alu_opcode, alu_shamt, alu_opA},
                           {22'd0, 5'd7, 5'd2, 32'h6a09e667});
    check("s0_busy", {62'd0, busy, req_ready}, {62'd0, 1'b1, 1'b0});
    wait_rsp("s0", 5, 32'hce20b47e, 1'b0);
    finish_rsp("s0");

    start_req(2'd1, 32'h510e527f, 32'd0, 32'd0);
    wait_rsp("s1", 5, 32'h3587272b, 1'b0);
    finish_rsp("s1");

    start_req(2'd0, 32'h00000001, 32'd0, 32'd0);
    wait_rsp("s0_wrap", 5, 32'h40080400, 1'b0);
    finish_rsp("s0_wrap");

    start_req(2'd2, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372);
    wait_rsp("maj", 5, 32'h3a6fe667, 1'b0);
    finish_rsp("maj");

    // Maj corner, then hold response for 10 cycles
    start_req(2'd2, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF);
    wait_rsp("maj_ones", 5, 32'hFFFFFFFF, 1'b0);
    held = rsp_data;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check("hold", {rsp_valid, req_ready, busy, alu_opcode, alu_shamt, rsp_data, alu_opA | alu_opB},
                    {1'b1, 1'b0, 1'b1, 5'd0, 5'd0, held, 32'd0});
    end
    finish_rsp("maj_ones");

    // Reset during step 2 aborts without a response
    start_req(2'd1, 32'h510e527f, 32'd0, 32'd0);
    @(posedge clock); #1;
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("midrst_out", {rsp_valid, rsp_err, busy, req_ready, rsp_data, 28'd0},
                        {1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 28'd0});
    check("midrst_alu", {alu_opA, alu_opB | {22'd0, alu_opcode, alu_shamt}}, 64'd0);
    @(negedge clock); reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      check("midrst_norsp", {62'd0, rsp_valid, busy}, 64'd0);
    end
    start_req(2'd0, 32'h6a09e667, 32'd0, 32'd0);
    wait_rsp("s0_after_rst", 5, 32'hce20b47e, 1'b0);
    finish_rsp("s0_after_rst");

    // Func 3
    start_req(2'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000002);
`ifdef SHA_SEQ_ADD3_EN
    wait_rsp("add3", 2, 32'h00000002, 1'b0);
`else
    wait_rsp("add3", 0, 32'h00000000, 1'b1);
`endif
    finish_rsp("add3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
